// File: rtl/riscv_pkg.sv
// RV32I decode definitions shared by the decode/issue slice: opcode constants,
// immediate formats, issue-slot states and the decode/immediate helpers.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef enum logic [1:0] {SLOT_EMPTY, SLOT_STALL, SLOT_ISSUE_RDY} slot_state_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       writes_rd;
    logic       illegal;
    imm_fmt_e   imm_fmt;
  } dec_t;

  // writes_rd is only reported when a real register (rd != x0) is written.
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.opcode    = instr[6:0];
    d.funct3    = instr[14:12];
    d.funct7b5  = instr[30];
    d.rd        = instr[11:7];
    d.rs1       = instr[19:15];
    d.rs2       = instr[24:20];
    d.writes_rd = 1'b1;
    d.illegal   = 1'b0;
    d.imm_fmt   = IMM_NONE;
    case (instr[6:0])
      OPC_OP:                         d.imm_fmt = IMM_NONE;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: d.imm_fmt = IMM_I;
      OPC_STORE:  begin d.imm_fmt = IMM_S; d.writes_rd = 1'b0; end
      OPC_BRANCH: begin d.imm_fmt = IMM_B; d.writes_rd = 1'b0; end
      OPC_LUI, OPC_AUIPC:             d.imm_fmt = IMM_U;
      OPC_JAL:                        d.imm_fmt = IMM_J;
      default:    begin d.illegal = 1'b1; d.writes_rd = 1'b0; end
    endcase
    d.writes_rd = d.writes_rd && (instr[11:7] != 5'd0);
    return d;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/scoreboard.sv
// Per-register pending bits for in-flight writes; x0 never becomes pending.
module scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_valid,
  input  logic [4:0] set_addr,
  input  logic       clr_valid,
  input  logic [4:0] clr_addr,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic [4:0] rd_addr,
  output logic       rs1_pending,
  output logic       rs2_pending,
  output logic       rd_pending
);

  logic [31:0] pending;
  logic [31:0] pending_next;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // Next pending vector: the set mask is OR-ed in after the clear so set wins.
  always_comb begin
    clr_mask     = clr_valid ? (32'h0000_0001 << clr_addr) : 32'h0000_0000;
    set_mask     = (set_valid && (set_addr != 5'd0)) ? (32'h0000_0001 << set_addr) : 32'h0000_0000;
    pending_next = (pending & ~clr_mask) | set_mask;
  end

  // Pending state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 32'h0000_0000;
    end else begin
      pending <= pending_next;
    end
  end

  assign rs1_pending = pending[rs1_addr];
  assign rs2_pending = pending[rs2_addr];
  assign rd_pending  = pending[rd_addr];

endmodule

// File: rtl/decode_issue.sv
// Single-slot RV32I decode and issue stage: holds one instruction, stalls on
// scoreboard hazards, and issues decoded fields plus operands to a ready/valid output.
module decode_issue
  import riscv_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic [4:0]        read_addr_1,
  output logic [4:0]        read_addr_2,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic              wb_valid,
  input  logic [4:0]        wb_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic              out_funct7b5,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_rs1_data,
  output logic [DATA_W-1:0] out_rs2_data,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_writes_rd,
  output logic              out_illegal
);

  logic        slot_full;
  logic [31:0] slot_instr;
  dec_t        dec;
  logic [31:0] imm32;
  logic        rs1_pend;
  logic        rs2_pend;
  logic        rd_pend;
  logic        hazard;
  logic        issue;
  logic        capture;
  slot_state_e slot_state;

  // Decode the held word, classify the slot and derive the handshakes.
  always_comb begin
    dec    = decode(slot_instr);
    imm32  = imm_gen(slot_instr, dec.imm_fmt);
    hazard = rs1_pend || rs2_pend || (dec.writes_rd && rd_pend);
    if (!slot_full) begin
      slot_state = SLOT_EMPTY;
    end else if (hazard) begin
      slot_state = SLOT_STALL;
    end else begin
      slot_state = SLOT_ISSUE_RDY;
    end
    issue    = (slot_state == SLOT_ISSUE_RDY) && (!out_valid || out_ready);
    in_ready = !rst && (!slot_full || issue);
    capture  = in_valid && in_ready;
  end

  assign read_addr_1 = dec.rs1;
  assign read_addr_2 = dec.rs2;

  scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_valid   (issue && dec.writes_rd),
    .set_addr    (dec.rd),
    .clr_valid   (wb_valid),
    .clr_addr    (wb_addr),
    .rs1_addr    (dec.rs1),
    .rs2_addr    (dec.rs2),
    .rd_addr     (dec.rd),
    .rs1_pending (rs1_pend),
    .rs2_pending (rs2_pend),
    .rd_pending  (rd_pend)
  );

  // Held-instruction slot: refilled on capture, emptied on issue without refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_full  <= 1'b0;
      slot_instr <= 32'h0000_0000;
    end else if (capture) begin
      slot_full  <= 1'b1;
      slot_instr <= in_instr;
    end else if (issue) begin
      slot_full  <= 1'b0;
    end
  end

  // Output register: loads on issue, otherwise holds until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_opcode    <= 7'd0;
      out_funct3    <= 3'd0;
      out_funct7b5  <= 1'b0;
      out_rd        <= 5'd0;
      out_rs1_data  <= '0;
      out_rs2_data  <= '0;
      out_imm       <= '0;
      out_writes_rd <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (issue) begin
      out_valid     <= 1'b1;
      out_opcode    <= dec.opcode;
      out_funct3    <= dec.funct3;
      out_funct7b5  <= dec.funct7b5;
      out_rd        <= dec.rd;
      out_rs1_data  <= read_data_1;
      out_rs2_data  <= read_data_2;
      out_imm       <= DATA_W'(imm32);
      out_writes_rd <= dec.writes_rd;
      out_illegal   <= dec.illegal;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed sequences with literal expectations, then
// randomised traffic compared every cycle against a behavioural issue model.
module tb_decode_issue;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, wb_valid, out_valid, out_ready;
  logic          out_funct7b5, out_writes_rd, out_illegal;
  logic [31:0]   in_instr;
  logic [4:0]    read_addr_1, read_addr_2, wb_addr, out_rd;
  logic [DW-1:0] read_data_1, read_data_2, out_rs1_data, out_rs2_data, out_imm;
  logic [6:0]    out_opcode;
  logic [2:0]    out_funct3;

  logic [DW-1:0] regs [32];
  assign read_data_1 = regs[read_addr_1];
  assign read_data_2 = regs[read_addr_2];

  decode_issue #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
    .out_rd(out_rd), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_writes_rd(out_writes_rd), .out_illegal(out_illegal)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: held instruction, pending set, and the output register contents.
  bit            m_full;
  logic [31:0]   m_instr;
  bit            m_pend [32];
  bit            m_ov, m_f7, m_wr, m_ill;
  logic [6:0]    m_op;
  logic [2:0]    m_f3;
  logic [4:0]    m_rd;
  logic [DW-1:0] m_a, m_b, m_imm;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
  endtask

  task automatic model_reset();
    m_full = 1'b0; m_instr = 32'h0; m_ov = 1'b0; m_f7 = 1'b0; m_wr = 1'b0; m_ill = 1'b0;
    m_op = 7'h0; m_f3 = 3'h0; m_rd = 5'h0; m_a = '0; m_b = '0; m_imm = '0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
  endtask

  // Instruction semantics written from the ISA tables with plain arithmetic.
  function automatic void mdec(input logic [31:0] w, output bit ill, output bit wr, output logic [31:0] imm);
    logic signed [31:0] s;
    logic [31:0] t20, t25, t31;
    s = w; t20 = s >>> 20; t25 = s >>> 25; t31 = s >>> 31;
    ill = 1'b0; wr = 1'b0; imm = 32'h0;
    case (w[6:0])
      7'h33:               wr = 1'b1;
      7'h13, 7'h03, 7'h67: begin wr = 1'b1; imm = t20; end
      7'h23:               imm = (t25 << 5) | 32'(w[11:7]);
      7'h63:               imm = (t31 << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      7'h37, 7'h17:        begin wr = 1'b1; imm = w & 32'hFFFF_F000; end
      7'h6F:               begin wr = 1'b1; imm = (t31 << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1); end
      default:             ill = 1'b1;
    endcase
    if (w[11:7] == 5'd0) wr = 1'b0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F};
    logic [31:0] w;
    w        = $urandom;
    w[6:0]   = ops[$urandom_range(0, 9)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  // One clock cycle: drive inputs, compare at the falling edge, advance the model after the edge.
  task automatic step(input bit r, input bit iv, input logic [31:0] ins, input bit wv,
                      input logic [4:0] wa, input logic [DW-1:0] wd, input bit ordy,
                      output bit seen_ready, output bit seen_valid);
    bit hz, iss, inr, cap, ill, wr;
    logic [31:0] imm;
    logic [4:0] rs1, rs2, rd;
    rst = r; in_valid = iv; in_instr = ins; wb_valid = wv; wb_addr = wa; out_ready = ordy;
    rs1 = m_instr[19:15]; rs2 = m_instr[24:20]; rd = m_instr[11:7];
    mdec(m_instr, ill, wr, imm);
    hz  = m_pend[rs1] || m_pend[rs2] || (wr && m_pend[rd]);
    iss = m_full && !hz && (!m_ov || ordy);
    inr = !r && (!m_full || iss);
    cap = iv && inr;
    #4;
    seen_ready = in_ready;
    seen_valid = out_valid;
    chk("in_ready", 64'(in_ready), 64'(inr));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_ctrl", 64'({out_opcode, out_funct3, out_funct7b5, out_rd, out_writes_rd, out_illegal}),
        64'({m_op, m_f3, m_f7, m_rd, m_wr, m_ill}));
    chk("out_data", 64'({out_rs1_data, out_rs2_data, out_imm}), 64'({m_a, m_b, m_imm}));
    if (m_full) chk("read_addr", 64'({read_addr_1, read_addr_2}), 64'({rs1, rs2}));
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if (iss) begin
        m_ov = 1'b1; m_op = m_instr[6:0]; m_f3 = m_instr[14:12]; m_f7 = m_instr[30]; m_rd = rd;
        m_a = regs[rs1]; m_b = regs[rs2]; m_imm = imm[DW-1:0]; m_wr = wr; m_ill = ill;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      if (wv) m_pend[wa] = 1'b0;
      if (iss && wr) m_pend[rd] = 1'b1;
      if (cap) begin
        m_full = 1'b1; m_instr = ins;
      end else if (iss) begin
        m_full = 1'b0;
      end
    end
    if (wv && wa != 5'd0) regs[wa] = wd;
  endtask

  bit   sr, sv, rr, ivr, wvr, ordr;
  logic [4:0] war;
  int   pq [$];

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? '0 : DW'($urandom);
    model_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; wb_valid = 1'b0; wb_addr = 5'd0; out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles, then release.
    repeat (2) begin
      step(1, 0, 32'h0, 0, 5'd0, '0, 1, sr, sv);
      chk("rst_in_ready", 64'(sr), 64'd0);
      chk("rst_out_valid", 64'(sv), 64'd0);
    end
    step(0, 0, 32'h0, 0, 5'd0, '0, 1, sr, sv);
    chk("release_in_ready", 64'(sr), 64'd1);

    // Back-to-back independent addi.
    step(0, 1, 32'h0030_0293, 0, 5'd0, '0, 1, sr, sv);
    step(0, 1, 32'h0010_0393, 0, 5'd0, '0, 1, sr, sv);
    chk("b2b_in_ready", 64'(sr), 64'd1);
    chk("b2b_valid1", 64'(out_valid), 64'd1);
    chk("b2b_rd1", 64'(out_rd), 64'd5);
    chk("b2b_imm1", 64'(out_imm), 64'h03);
    step(0, 0, 32'h0, 0, 5'd0, '0, 1, sr, sv);
    chk("b2b_valid2", 64'(out_valid), 64'd1);
    chk("b2b_rd2", 64'(out_rd), 64'd7);
    chk("b2b_imm2", 64'(out_imm), 64'h01);
    step(0, 0, 32'h0, 0, 5'd0, '0, 1, sr, sv);
    step(0, 0, 32'h0, 1, 5'd7, 8'h11, 1, sr, sv);

    // RAW stall on x5, released by a writeback of 3.
    step(0, 1, 32'h0052_8333, 0, 5'd0, '0, 1, sr, sv);
    repeat (3) begin
      step(0, 0, 32'h0, 0, 5'd0, '0, 1, sr, sv);
      chk("raw_stall_ready", 64'(sr), 64'd0);
      chk("raw_stall_valid", 64'(sv), 64'd0);
    end
    step(0, 0, 32'h0, 1, 5'd5, 8'h03, 1, sr, sv);
    chk("raw_k_valid", 64'(sv), 64'd0);
    chk("raw_k1_valid", 64'(out_valid), 64'd0);
    step(0, 0, 32'h0, 0, 5'd0, '0, 1, sr, sv);
    chk("raw_k2_valid", 64'(out_valid), 64'd1);
    chk("raw_k2_rd", 64'(out_rd), 64'd6);
    chk("raw_k2_rs1", 64'(out_rs1_data), 64'h03);
    chk("raw_k2_rs2", 64'(out_rs2_data), 64'h03);
    step(0, 0, 32'h0, 0, 5'd0, '0, 1, sr, sv);
    step(0, 0, 32'h0, 1, 5'd6, 8'h22, 1, sr, sv);

    // Backpressure: addi x8,x0,9 held three cycles while addi x9,x0,4 waits.
    step(0, 1, 32'h0090_0413, 0, 5'd0, '0, 0, sr, sv);
    step(0, 1, 32'h0040_0493, 0, 5'd0, '0, 0, sr, sv);
    repeat (3) begin
      step(0, 0, 32'h0, 0, 5'd0, '0, 0, sr, sv);
      chk("bp_in_ready", 64'(sr), 64'd0);
      chk("bp_valid", 64'(sv), 64'd1);
      chk("bp_rd", 64'(out_rd), 64'd8);
      chk("bp_imm", 64'(out_imm), 64'h09);
    end
    step(0, 0, 32'h0, 0, 5'd0, '0, 1, sr, sv);
    chk("bp_next_valid", 64'(out_valid), 64'd1);
    chk("bp_next_rd", 64'(out_rd), 64'd9);
    chk("bp_next_imm", 64'(out_imm), 64'h04);
    step(0, 0, 32'h0, 1, 5'd8, 8'h33, 1, sr, sv);
    step(0, 0, 32'h0, 1, 5'd9, 8'h44, 1, sr, sv);

    // Writes to x0 reserve nothing; the following add issues without a bubble.
    step(0, 1, 32'h0050_0013, 0, 5'd0, '0, 1, sr, sv);
    step(0, 1, 32'h0000_0333, 0, 5'd0, '0, 1, sr, sv);
    chk("x0_in_ready", 64'(sr), 64'd1);
    chk("x0_writes_rd", 64'(out_writes_rd), 64'd0);
    chk("x0_imm", 64'(out_imm), 64'h05);
    step(0, 0, 32'h0, 0, 5'd0, '0, 1, sr, sv);
    chk("x0_next_valid", 64'(out_valid), 64'd1);
    chk("x0_next_rd", 64'(out_rd), 64'd6);
    step(0, 0, 32'h0, 1, 5'd6, 8'h55, 1, sr, sv);

    // Writeback to x5 in the same cycle addi x5 issues: the set survives.
    step(0, 1, 32'h0030_0293, 0, 5'd0, '0, 1, sr, sv);
    step(0, 1, 32'h0052_8333, 1, 5'd5, 8'h66, 1, sr, sv);
    chk("setwin_capture", 64'(sr), 64'd1);
    step(0, 0, 32'h0, 0, 5'd0, '0, 1, sr, sv);
    chk("setwin_stall", 64'(sr), 64'd0);
    step(0, 0, 32'h0, 1, 5'd5, 8'h77, 1, sr, sv);
    step(0, 0, 32'h0, 0, 5'd0, '0, 1, sr, sv);
    step(0, 0, 32'h0, 1, 5'd6, 8'h12, 1, sr, sv);

    // Unknown opcode.
    step(0, 1, 32'hFFFF_FFFF, 0, 5'd0, '0, 1, sr, sv);
    step(0, 0, 32'h0, 0, 5'd0, '0, 1, sr, sv);
    chk("illegal_valid", 64'(out_valid), 64'd1);
    chk("illegal_flag", 64'(out_illegal), 64'd1);
    chk("illegal_writes_rd", 64'(out_writes_rd), 64'd0);
    chk("illegal_imm", 64'(out_imm), 64'h00);

    // Random traffic with hazards, backpressure, writebacks and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rr   = ($urandom_range(0, 299) == 0);
      ivr  = ($urandom_range(0, 3) != 0);
      ordr = ($urandom_range(0, 3) != 0);
      wvr  = 1'b0;
      war  = 5'd0;
      if ($urandom_range(0, 2) == 0) begin
        pq.delete();
        for (int i = 1; i < 32; i++) if (m_pend[i]) pq.push_back(i);
        if (pq.size() > 0) begin
          wvr = 1'b1;
          war = 5'(pq[$urandom_range(0, pq.size() - 1)]);
        end else if ($urandom_range(0, 3) == 0) begin
          wvr = 1'b1;
          war = 5'($urandom_range(0, 7));
        end
      end
      step(rr, ivr, rand_instr(), wvr, war, DW'($urandom), ordr, sr, sv);
    end
    repeat (4) step(0, 0, 32'h0, 0, 5'd0, '0, 1, sr, sv);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
